// File: rtl/mp_pipe.sv
// mp_pipe: 3-stage pipelined ALU core with a register file, forwarding and debug preload.
// Define MP_PIPE_STATS_EN to add the retired_cnt/dropped_cnt counter outputs.
module mp_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] result,
    output logic [ADDR_W-1:0] result_dst,
    output logic              result_valid,
    input  logic              result_ready,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata
`ifdef MP_PIPE_STATS_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       dropped_cnt
`endif
);
    localparam int REG_CNT = 2**ADDR_W;

    logic [DATA_W-1:0] regs [REG_CNT];
    logic              stall;
    logic              s1_valid;
    logic [5:0]        s1_op;
    logic [ADDR_W-1:0] s1_src1, s1_src2, s1_dst;
    logic              s2_valid;
    logic [5:0]        s2_op;
    logic [ADDR_W-1:0] s2_dst;
    logic [DATA_W-1:0] s2_a, s2_b;
    logic              s2_ok, s2_live, wb;
    logic [DATA_W:0]   sum;
    logic              lt;
    logic [DATA_W-1:0] alu, op_a, op_b;
    logic              unused_hi;

    assign unused_hi   = ^(instr >> (6 + 3 * ADDR_W));
    assign stall       = result_valid && !result_ready;
    assign instr_ready = !stall;

    assign s2_ok   = s2_op inside {6'b000101, 6'b001000, 6'b001101, 6'b000111, 6'b000011, 6'b000110,
                                   6'b000010, 6'b001111, 6'b000100, 6'b001100, 6'b001010};
    assign s2_live = s2_valid && s2_ok;
    assign wb      = s2_live && !stall;

    // avg needs the sum one bit wider so the carry survives the arithmetic shift
    assign sum = {s2_a[DATA_W-1], s2_a} + {s2_b[DATA_W-1], s2_b};
    assign lt  = $signed(s2_a) < $signed(s2_b);

    always_comb begin
        case (s2_op)
            6'b000101: alu = s2_a + s2_b;
            6'b001000: alu = s2_a - s2_b;
            6'b001101: alu = s2_a[DATA_W-1] ? -s2_a : s2_a;
            6'b000111: alu = -s2_a;
            6'b000011: alu = lt ? s2_b : s2_a;
            6'b000110: alu = lt ? s2_a : s2_b;
            6'b000010: alu = ~s2_a;
            6'b001111: alu = s2_a | s2_b;
            6'b000100: alu = s2_a & s2_b;
            6'b001100: alu = s2_a ^ s2_b;
            6'b001010: alu = sum[DATA_W:1];
            default:   alu = '0;
        endcase
    end

    // The instruction in S2 writes back on the same edge S1 reads, so bypass it
    assign op_a = (s2_live && s2_dst == s1_src1) ? alu : regs[s1_src1];
    assign op_b = (s2_live && s2_dst == s1_src2) ? alu : regs[s1_src2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '{default: '0};
        end else begin
            if (dbg_we)
                regs[dbg_addr] <= dbg_wdata;
            if (wb)
                regs[s2_dst] <= alu;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_op        <= '0;
            s1_src1      <= '0;
            s1_src2      <= '0;
            s1_dst       <= '0;
            s2_valid     <= 1'b0;
            s2_op        <= '0;
            s2_dst       <= '0;
            s2_a         <= '0;
            s2_b         <= '0;
            result_valid <= 1'b0;
            result       <= '0;
            result_dst   <= '0;
        end else if (!stall) begin
            s1_valid     <= instr_valid;
            s1_op        <= instr[5:0];
            s1_src1      <= instr[6 +: ADDR_W];
            s1_src2      <= instr[6 + ADDR_W +: ADDR_W];
            s1_dst       <= instr[6 + 2 * ADDR_W +: ADDR_W];
            s2_valid     <= s1_valid;
            s2_op        <= s1_op;
            s2_dst       <= s1_dst;
            s2_a         <= op_a;
            s2_b         <= op_b;
            result_valid <= s2_live;
            if (s2_live) begin
                result     <= alu;
                result_dst <= s2_dst;
            end
        end
    end

`ifdef MP_PIPE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= '0;
            dropped_cnt <= '0;
        end else begin
            if (result_valid && result_ready)
                retired_cnt <= retired_cnt + 32'd1;
            if (!stall && s2_valid && !s2_ok)
                dropped_cnt <= dropped_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mp_pipe.sv
// tb_mp_pipe: directed bench for mp_pipe with a sequential reference model scoreboard.
module tb_mp_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] result;
    logic [4:0]  result_dst;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic        dbg_we = 1'b0;
    logic [4:0]  dbg_addr = '0;
    logic [31:0] dbg_wdata = '0;
    int          checks = 0;
    int          errors = 0;

    mp_pipe dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .result(result), .result_dst(result_dst), .result_valid(result_valid),
        .result_ready(result_ready), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] ADD = 6'b000101, SUB = 6'b001000, ABS = 6'b001101, NEG = 6'b000111,
                           MAX = 6'b000011, MIN = 6'b000110, NOT = 6'b000010, OR  = 6'b001111,
                           AND = 6'b000100, XOR = 6'b001100, AVG = 6'b001010, BAD = 6'b001001;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input int s1, input int s2, input int d);
        return {11'd0, 5'(d), 5'(s2), 5'(s1), op};
    endfunction

    // Returns {valid_opcode, value} computed with plain integer arithmetic
    function automatic logic [32:0] alu_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb;
        longint s;
        sa = a;
        sb = b;
        s  = longint'(sa) + longint'(sb);
        case (op)
            ADD:     return {1'b1, a + b};
            SUB:     return {1'b1, a - b};
            ABS:     return {1'b1, (sa < 0) ? 32'(-sa) : a};
            NEG:     return {1'b1, 32'(-sa)};
            MAX:     return {1'b1, (sa > sb) ? a : b};
            MIN:     return {1'b1, (sa < sb) ? a : b};
            NOT:     return {1'b1, ~a};
            OR:      return {1'b1, a | b};
            AND:     return {1'b1, a & b};
            XOR:     return {1'b1, a ^ b};
            AVG:     return {1'b1, 32'(s >>> 1)};
            default: return 33'd0;
        endcase
    endfunction

    typedef struct packed {
        logic [4:0]  dst;
        logic [31:0] val;
    } res_t;

    logic [31:0] mregs [32];
    res_t        exp_q [$];
    logic [32:0] mr;

    // Scoreboard: executes accepted instructions in program order, checks every output cycle
    always @(negedge clk) begin
        if (rst) begin
            foreach (mregs[i]) mregs[i] = '0;
            exp_q.delete();
        end else begin
            chk("instr_ready", instr_ready, !(result_valid && !result_ready));
            if (result_valid) begin
                if (exp_q.size() == 0)
                    chk("unexpected result_valid", result_valid, 0);
                else begin
                    chk("model result", result, exp_q[0].val);
                    chk("model result_dst", result_dst, exp_q[0].dst);
                    if (result_ready) void'(exp_q.pop_front());
                end
            end
            if (dbg_we) mregs[dbg_addr] = dbg_wdata;
            if (instr_valid && instr_ready) begin
                mr = alu_model(instr[5:0], mregs[instr[10:6]], mregs[instr[15:11]]);
                if (mr[32]) begin
                    mregs[instr[20:16]] = mr[31:0];
                    exp_q.push_back({instr[20:16], mr[31:0]});
                end
            end
        end
    end

    logic [31:0] s_ins [8];
    logic [31:0] s_exp [8];
    logic [4:0]  s_dst [8];
    logic        s_ok  [8];
    int          s_n;

    task automatic put(input int i, input logic [31:0] ins, input logic [31:0] e, input int d, input logic ok);
        s_ins[i] = ins;
        s_exp[i] = e;
        s_dst[i] = 5'(d);
        s_ok[i]  = ok;
        s_n      = i + 1;
    endtask

    // Issues s_ins back to back from an empty pipe; result k must appear at acceptance+2
    task automatic run_stream(input string name);
        instr       = s_ins[0];
        instr_valid = 1'b1;
        for (int k = 0; k <= s_n + 1; k++) begin
            @(posedge clk); #1;
            instr_valid = (k + 1 < s_n);
            if (k + 1 < s_n) instr = s_ins[k + 1];
            if (k < 2)
                chk({name, " early valid"}, result_valid, 0);
            else begin
                chk($sformatf("%s[%0d] valid", name, k - 2), result_valid, s_ok[k - 2]);
                chk($sformatf("%s[%0d] result", name, k - 2), result, s_exp[k - 2]);
                if (s_ok[k - 2]) chk($sformatf("%s[%0d] dst", name, k - 2), result_dst, s_dst[k - 2]);
            end
        end
        @(posedge clk); #1;
        chk({name, " idle"}, result_valid, 0);
    endtask

    task automatic dbg(input int a, input logic [31:0] d);
        dbg_we    = 1'b1;
        dbg_addr  = 5'(a);
        dbg_wdata = d;
        @(posedge clk); #1;
        dbg_we = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset result", result, 0);
        chk("reset result_dst", result_dst, 0);
        chk("reset result_valid", result_valid, 0);
        rst = 1'b0;
        #1;
        chk("reset instr_ready", instr_ready, 1);
        @(posedge clk); #1;

        dbg(1, 32'h1066);
        dbg(2, 32'h15DC);
        put(0, enc(ADD, 1, 2, 3), 32'h2642, 3, 1'b1);
        run_stream("add");

        dbg(3, 32'h0);
        put(0, enc(ADD, 1, 2, 3), 32'h2642, 3, 1'b1);
        put(1, enc(SUB, 3, 1, 4), 32'h15DC, 4, 1'b1);
        put(2, enc(OR, 1, 4, 8), 32'h15FE, 8, 1'b1);
        run_stream("fwd");

        result_ready = 1'b0;
        instr = enc(AND, 1, 2, 9);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr = enc(XOR, 9, 2, 10);
        @(posedge clk); #1;
        instr = enc(NEG, 10, 0, 11);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("stall instr_ready", instr_ready, 0);
            chk("stall valid", result_valid, 1);
            chk("stall result", result, 32'h1044);
            chk("stall dst", result_dst, 9);
            if (j < 2) begin
                @(posedge clk); #1;
            end
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain 1 result", result, 32'h0598);
        chk("drain 1 dst", result_dst, 10);
        @(posedge clk); #1;
        chk("drain 2 result", result, 32'hFFFFFA68);
        chk("drain 2 dst", result_dst, 11);
        @(posedge clk); #1;
        chk("drain idle", result_valid, 0);

        put(0, enc(BAD, 1, 2, 3), 32'hFFFFFA68, 3, 1'b0);
        put(1, enc(ADD, 3, 0, 5), 32'h2642, 5, 1'b1);
        run_stream("bubble");

        dbg(6, 32'h80000000);
        dbg(7, 32'h7FFFFFFF);
        put(0, enc(ABS, 6, 0, 12), 32'h80000000, 12, 1'b1);
        put(1, enc(AVG, 7, 7, 13), 32'h7FFFFFFF, 13, 1'b1);
        put(2, enc(AVG, 6, 7, 14), 32'hFFFFFFFF, 14, 1'b1);
        put(3, enc(MAX, 6, 7, 15), 32'h7FFFFFFF, 15, 1'b1);
        put(4, enc(MIN, 6, 7, 16), 32'h80000000, 16, 1'b1);
        put(5, enc(NOT, 6, 0, 17), 32'h7FFFFFFF, 17, 1'b1);
        put(6, enc(ADD, 7, 7, 18), 32'hFFFFFFFE, 18, 1'b1);
        put(7, enc(ADD, 18, 18, 18), 32'hFFFFFFFC, 18, 1'b1);
        run_stream("edge");

        instr = enc(ADD, 1, 2, 19);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr = enc(ADD, 1, 1, 20);
        @(posedge clk); #1;
        instr = enc(OR, 2, 2, 21);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("pre-reset valid", result_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset valid", result_valid, 0);
        chk("async reset result", result, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            chk("post-reset quiet", result_valid, 0);
        end
        put(0, enc(OR, 1, 1, 22), 32'h0, 22, 1'b1);
        put(1, enc(OR, 2, 2, 23), 32'h0, 23, 1'b1);
        put(2, enc(OR, 3, 3, 24), 32'h0, 24, 1'b1);
        put(3, enc(OR, 6, 7, 25), 32'h0, 25, 1'b1);
        put(4, enc(ADD, 19, 20, 26), 32'h0, 26, 1'b1);
        put(5, enc(OR, 21, 18, 27), 32'h0, 27, 1'b1);
        run_stream("cleared");

        chk("scoreboard leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
